// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter: state encoding,
// index-width helper and the default forced-release beat limit.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int DEF_MAX_BEATS = 64;

    // Index width for an n-entry requester set; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo NUM_REQ. No latency, no flow control.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic               any_o,
    output logic [IW-1:0]      idx_o
);

    int j;

    // Scan farthest-first so the candidate closest to the pointer wins.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        j     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (req_i[j]) begin
                any_o = 1'b1;
                idx_o = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter feeding one FIFO write port through a single
// output register; ARB_PKT_LIMIT_EN adds a forced release after MAX_BEATS beats.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BEATS  = DEF_MAX_BEATS,
    localparam int IW        = idx_w(NUM_REQ)
) (
    input  logic                          clkIn,
    input  logic                          rstIn,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] reqDataIn,
    input  logic [NUM_REQ-1:0]            reqValidIn,
    input  logic [NUM_REQ-1:0]            reqLastIn,
    output logic [NUM_REQ-1:0]            reqReadyOut,
    output logic [DATA_WIDTH-1:0]         wrDataOut,
    output logic                          wrValidOut,
    input  logic                          wrReadyIn,
    output logic [IW-1:0]                 grantIdOut,
    output logic                          busyOut
);

    arb_state_e            state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [IW-1:0]         grant_q, grant_d;
    logic                  out_vld_q, out_vld_d;
    logic [DATA_WIDTH-1:0] out_dat_q, out_dat_d;

    logic                  pick_any;
    logic [IW-1:0]         pick_idx;
    logic                  locked;
    logic                  slot_free;
    logic                  accept;
    logic                  limit_hit;
    logic                  release_pkt;
    logic [DATA_WIDTH-1:0] sel_dat;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_pick (
        .req_i (reqValidIn),
        .ptr_i (ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    assign locked      = (state_q == LOCKED);
    assign sel_dat     = reqDataIn[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    // The output slot can take a beat if empty or if its current beat leaves now.
    assign slot_free   = !out_vld_q || wrReadyIn;
    assign accept      = locked && reqValidIn[grant_q] && slot_free;
    assign release_pkt = accept && (reqLastIn[grant_q] || limit_hit);

`ifdef ARB_PKT_LIMIT_EN
    localparam int CW = $clog2(MAX_BEATS + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    assign limit_hit = (cnt_q == CW'(MAX_BEATS - 1));
`else
    assign limit_hit = 1'b0;
`endif

    always_comb begin
        reqReadyOut = '0;
        if (locked) begin
            reqReadyOut[grant_q] = slot_free;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
`ifdef ARB_PKT_LIMIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = LOCKED;
                    grant_d = pick_idx;
`ifdef ARB_PKT_LIMIT_EN
                    cnt_d   = '0;
`endif
                end
            end
            LOCKED: begin
                if (release_pkt) begin
                    state_d = IDLE;
                    ptr_d   = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                end
`ifdef ARB_PKT_LIMIT_EN
                else if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register drains on its own, independent of the arbiter state.
    always_comb begin
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        if (accept) begin
            out_vld_d = 1'b1;
            out_dat_d = sel_dat;
        end else if (wrReadyIn) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
`ifdef ARB_PKT_LIMIT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
`ifdef ARB_PKT_LIMIT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign wrValidOut = out_vld_q;
    assign wrDataOut  = out_dat_q;
    assign grantIdOut = grant_q;
    assign busyOut    = locked;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised scoreboard bench for fifo_wr_arbiter: per-requester packet queues,
// a round-robin grant model and output-register rules checked at each negedge.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
`ifdef ARB_PKT_LIMIT_EN
    localparam int TB_MAX = 4;
`else
    localparam int TB_MAX = 64;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N*DW-1:0] req_dat;
    logic [N-1:0]  req_vld, req_last, req_rdy;
    logic [DW-1:0] wr_dat;
    logic          wr_vld, wr_rdy;
    logic [1:0]    gid;
    logic          busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (N),
        .MAX_BEATS  (TB_MAX)
    ) dut (
        .clkIn       (clk),
        .rstIn       (rst),
        .reqDataIn   (req_dat),
        .reqValidIn  (req_vld),
        .reqLastIn   (req_last),
        .reqReadyOut (req_rdy),
        .wrDataOut   (wr_dat),
        .wrValidOut  (wr_vld),
        .wrReadyIn   (wr_rdy),
        .grantIdOut  (gid),
        .busyOut     (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Beat tag: requester, packet number, beat number, last flag in bit 0.
    function automatic logic [DW-1:0] mk_beat(input int r, input int p, input int b, input bit last);
        return {4'(r), 12'(p), 8'(b), 7'd0, last};
    endfunction

    function automatic int rr(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // Stimulus controls (set by the main sequence)
    bit           gen_en = 0;
    logic [N-1:0] mask = '0;
    int           fixed_len = 0;
    int           vld_pct = 100;
    int           rdy_pct = 100;
    int           stall_cycles = 0;

    // Requester state and scoreboard
    int  rem [N];
    int  plen [N];
    int  pkt_no [N];
    int  beat_no [N];
    bit  offering [N];
    bit  acc [N];
    logic [DW-1:0] exp_q [N][$];

    function automatic bit all_idle();
        for (int r = 0; r < N; r++) begin
            if (rem[r] != 0 || exp_q[r].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Driver: changes inputs 1 time unit after each rising edge.
    initial begin
        req_vld  = '0;
        req_last = '0;
        req_dat  = '0;
        wr_rdy   = 1'b1;
        for (int r = 0; r < N; r++) begin
            rem[r] = 0; plen[r] = 0; pkt_no[r] = 0; beat_no[r] = 0; offering[r] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                req_vld  = '0;
                req_last = '0;
                for (int r = 0; r < N; r++) begin
                    rem[r] = 0;
                    offering[r] = 0;
                    exp_q[r].delete();
                end
            end else begin
                for (int r = 0; r < N; r++) begin
                    if (acc[r]) begin
                        offering[r] = 0;
                        rem[r]--;
                        beat_no[r]++;
                        req_vld[r] = 1'b0;
                    end
                    if (rem[r] == 0 && gen_en && mask[r] && $urandom_range(3) == 0) begin
                        plen[r] = (fixed_len > 0) ? fixed_len : int'($urandom_range(6, 1));
                        pkt_no[r]++;
                        beat_no[r] = 0;
                        rem[r] = plen[r];
                        for (int b = 0; b < plen[r]; b++) begin
                            exp_q[r].push_back(mk_beat(r, pkt_no[r], b, b == plen[r] - 1));
                        end
                    end
                    if (rem[r] > 0 && !offering[r] && $urandom_range(99) < vld_pct) begin
                        offering[r] = 1;
                        req_vld[r]  = 1'b1;
                        req_last[r] = (beat_no[r] == plen[r] - 1);
                        req_dat[r*DW +: DW] = mk_beat(r, pkt_no[r], beat_no[r], beat_no[r] == plen[r] - 1);
                    end
                end
                if (stall_cycles > 0) begin
                    wr_rdy = 1'b0;
                    stall_cycles--;
                end else begin
                    wr_rdy = ($urandom_range(99) < rdy_pct);
                end
            end
        end
    end

    // Monitor: all signals are stable at the falling edge; handshakes seen here
    // complete at the next rising edge.
    initial begin
        bit           prev_busy, prev_wv, prev_wrdy, prev_acc, prev_rel;
        bit           cur_acc, cur_rel, exp_wv;
        logic [N-1:0] prev_vld;
        logic [DW-1:0] prev_wd, prev_beat, cur_beat, e;
        int           model_ptr, model_grant, seg_cnt, out_r, out_cnt, r;
        prev_busy = 0; prev_wv = 0; prev_wrdy = 0; prev_acc = 0; prev_rel = 0;
        prev_vld = '0; prev_wd = '0; prev_beat = '0;
        model_ptr = 0; model_grant = 0; seg_cnt = 0; out_r = -1; out_cnt = 0;
        for (int i = 0; i < N; i++) acc[i] = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_busy = 0; prev_wv = 0; prev_wrdy = 0; prev_acc = 0; prev_rel = 0;
                prev_vld = '0; model_ptr = 0; model_grant = 0; seg_cnt = 0;
                out_r = -1; out_cnt = 0;
                for (int i = 0; i < N; i++) acc[i] = 0;
                continue;
            end
            if (prev_busy) begin
                check("grant_hold_release", busy, !prev_rel);
                if (!busy) model_ptr = (model_grant + 1) % N;
            end else begin
                check("idle_to_grant", busy, prev_vld != '0);
                if (busy) begin
                    model_grant = rr(prev_vld, model_ptr);
                    check("rr_grant", gid, model_grant);
                    seg_cnt = 0;
                end
            end
            if (!busy) begin
                check("idle_ready", req_rdy, '0);
            end else begin
                check("ready_onehot", req_rdy & ~(N'(1) << gid), '0);
                check("ready_rule", req_rdy[gid], !wr_vld || wr_rdy);
            end
            cur_acc = 0; cur_rel = 0; cur_beat = '0;
            for (int i = 0; i < N; i++) begin
                acc[i] = req_vld[i] && req_rdy[i];
                if (acc[i]) begin
                    check("accept_owner", i, model_grant);
                    cur_acc  = 1;
                    cur_beat = req_dat[i*DW +: DW];
                    seg_cnt++;
                    cur_rel  = req_last[i] || (seg_cnt == TB_MAX);
                end
            end
            exp_wv = prev_acc || (prev_wv && !prev_wrdy);
            check("wr_valid", wr_vld, exp_wv);
            if (prev_acc) check("wr_data_load", wr_dat, prev_beat);
            else if (exp_wv) check("wr_data_hold", wr_dat, prev_wd);
            if (wr_vld && wr_rdy) begin
                r = int'(wr_dat[31:28]);
                if (r >= N || exp_q[r].size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL wr_unexpected: got %0h expected no write at %0t", wr_dat, $time);
                end else begin
                    e = exp_q[r].pop_front();
                    check("wr_beat_order", wr_dat, e);
                end
                if (out_r >= 0) check("pkt_atomic", r, out_r);
                out_r = r;
                out_cnt++;
                if (wr_dat[0] || out_cnt == TB_MAX) begin
                    out_r = -1;
                    out_cnt = 0;
                end
            end
            prev_busy = busy; prev_vld = req_vld; prev_wv = wr_vld; prev_wd = wr_dat;
            prev_wrdy = wr_rdy; prev_acc = cur_acc; prev_beat = cur_beat; prev_rel = cur_rel;
        end
    end

    task automatic run_phase(input logic [N-1:0] m, input int fl, input int vp, input int rp, input int cyc);
        mask = m; fixed_len = fl; vld_pct = vp; rdy_pct = rp; gen_en = 1;
        repeat (cyc) @(posedge clk);
    endtask

    task automatic drain();
        int t;
        gen_en = 0;
        t = 0;
        while (t < 400 && !all_idle()) begin
            @(posedge clk);
            t++;
        end
        check("drain_done", all_idle(), 1'b1);
    endtask

    initial begin
        int t;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        check("rst_wr_valid", wr_vld, 1'b0);
        check("rst_wr_data", wr_dat, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", req_rdy, '0);
        check("rst_grant", gid, '0);
        rst = 1'b0;

        run_phase(4'b0100, 3, 100, 100, 40);   drain();
        run_phase(4'b1111, 2, 100, 100, 80);   drain();
        run_phase(4'b1111, 0, 80, 100, 30);
        @(posedge clk); #3 stall_cycles = 5;
        run_phase(4'b1111, 0, 80, 60, 200);    drain();
        run_phase(4'b0100, 1, 100, 100, 12);   drain();
        run_phase(4'b0001, 2, 100, 100, 12);   drain();
        run_phase(4'b1001, 3, 100, 100, 40);   drain();
        run_phase(4'b0011, 6, 100, 100, 60);   drain();
        for (int k = 0; k < 25; k++) begin
            run_phase(N'($urandom_range(15, 1)), 0, int'($urandom_range(100, 40)),
                      int'($urandom_range(100, 30)), 100);
        end
        drain();

        // Asynchronous reset in the middle of a packet
        run_phase(4'b1111, 5, 100, 50, 4);
        t = 0;
        while (t < 50 && !busy) begin
            @(posedge clk);
            t++;
        end
        check("busy_before_reset", busy, 1'b1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_wr_valid", wr_vld, 1'b0);
        check("arst_wr_data", wr_dat, '0);
        check("arst_busy", busy, 1'b0);
        check("arst_ready", req_rdy, '0);
        check("arst_grant", gid, '0);
        gen_en = 0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        run_phase(4'b0010, 3, 100, 100, 20);   drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
